// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with frame snapshot, leading-zero suppression and blink
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_blank,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DIGITS);
    localparam int CW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0]       p;
    logic [DW-1:0]       d;
    logic [4*DIGITS-1:0] f_bcd;
    logic [DIGITS-1:0]   f_dp;
    logic [DIGITS-1:0]   f_mask;
    logic                f_lz;
    logic                f_phase;
    logic [CW-1:0]       frame_cnt;
    logic                blink_phase;
    logic                snap;
    logic                p_wrap;
    logic                cnt_wrap;
    logic                run;
    logic [DIGITS-1:0]   sup;
    logic [3:0]          val;
    logic [6:0]          glyph;
    logic                blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0001100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        snap     = (p == '0) && (d == '0);
        p_wrap   = p == PW'(SCAN_DIV - 1);
        cnt_wrap = frame_cnt == CW'(BLINK_FRAMES - 1);
        val      = f_bcd[4*d +: 4];
        glyph    = decode(val);
    end

    // a zero run from the top digit stays suppressed until a non-zero or dp digit; digit 0 is always shown
    always_comb begin
        run = f_lz;
        sup = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run    = run & (f_bcd[4*i +: 4] == 4'd0) & ~f_dp[i];
            sup[i] = run;
        end
        blank = sup[d] | (f_phase & f_mask[d]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p           <= '0;
            d           <= '0;
            f_bcd       <= '0;
            f_dp        <= '0;
            f_mask      <= '0;
            f_lz        <= 1'b0;
            f_phase     <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= 8'hFF;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            p <= p_wrap ? '0 : p + 1'b1;
            if (p_wrap)
                d <= (d == DW'(DIGITS - 1)) ? '0 : d + 1'b1;
            // the phase toggled at this snapshot is latched into the frame at the next one
            if (snap) begin
                f_bcd       <= bcd;
                f_dp        <= dp_in;
                f_mask      <= blink_mask;
                f_lz        <= lz_blank;
                f_phase     <= blink_phase;
                frame_cnt   <= cnt_wrap ? '0 : frame_cnt + 1'b1;
                blink_phase <= cnt_wrap ? ~blink_phase : blink_phase;
            end
            frame_start <= snap;
            an          <= (p == '0) ? '1 : ~(DIGITS'(1) << d);
            seg         <= ((p == '0) || blank) ? 8'hFF : {glyph, ~f_dp[d]};
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of scan timing, decode, suppression, blink, snapshot and reset
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic        lz_blank;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;
    int          n_cmp = 0;
    int          n_bad = 0;

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bcd(bcd),
        .dp_in(dp_in),
        .blink_mask(blink_mask),
        .lz_blank(lz_blank),
        .seg(seg),
        .an(an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " an"}, {4'h0, an}, 8'h0F);
        chk({tag, " seg"}, seg, 8'hFF);
        chk({tag, " fs"}, {7'd0, frame_start}, 8'd0);
    endtask

    // steps through cycles 1..16 of a frame; e0..e3 are the expected seg values of digits 0..3
    task automatic run_frame(input string tag, input logic [7:0] e0, e1, e2, e3,
                             input int chg_j, input logic [15:0] chg_bcd);
        logic [7:0] es [4];
        es = '{e0, e1, e2, e3};
        for (int j = 1; j <= 16; j++) begin
            step();
            chk($sformatf("%s c%0d fs", tag, j), {7'd0, frame_start}, (j == 1) ? 8'd1 : 8'd0);
            if ((j - 1) % 4 == 0) begin
                chk($sformatf("%s c%0d an", tag, j), {4'h0, an}, 8'h0F);
                chk($sformatf("%s c%0d seg", tag, j), seg, 8'hFF);
            end else begin
                chk($sformatf("%s c%0d an", tag, j), {4'h0, an}, {4'h0, ~(4'b0001 << ((j - 1) / 4))});
                chk($sformatf("%s c%0d seg", tag, j), seg, es[(j - 1) / 4]);
            end
            if (j == chg_j) bcd = chg_bcd;
        end
    endtask

    initial begin
        bcd        = 16'h1234;
        dp_in      = 4'b0000;
        blink_mask = 4'b0000;
        lz_blank   = 1'b0;
        step();
        step();
        check_idle("in_reset");
        rst = 1'b0;
        check_idle("cycle0");
        run_frame("static", 8'h99, 8'h0D, 8'h25, 8'h9F, 0, 16'h0);
        bcd      = 16'h0050;
        lz_blank = 1'b1;
        run_frame("lz", 8'h03, 8'h49, 8'hFF, 8'hFF, 0, 16'h0);
        dp_in = 4'b0100;
        run_frame("lz_dp", 8'h03, 8'h49, 8'h02, 8'hFF, 0, 16'h0);
        bcd      = 16'h1234;
        dp_in    = 4'b0000;
        lz_blank = 1'b0;
        run_frame("pre_chg", 8'h99, 8'h0D, 8'h25, 8'h9F, 5, 16'h5678);
        run_frame("post_chg", 8'h01, 8'h1F, 8'h41, 8'h49, 0, 16'h0);
        bcd = 16'hABCD;
        run_frame("hex", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 16'h0);
        bcd        = 16'h1234;
        blink_mask = 4'b0011;
        repeat (9) step();
        rst = 1'b1;
        step();
        check_idle("mid_reset");
        rst = 1'b0;
        run_frame("blink0", 8'h99, 8'h0D, 8'h25, 8'h9F, 0, 16'h0);
        run_frame("blink1", 8'h99, 8'h0D, 8'h25, 8'h9F, 0, 16'h0);
        run_frame("blink2", 8'hFF, 8'hFF, 8'h25, 8'h9F, 0, 16'h0);
        run_frame("blink3", 8'hFF, 8'hFF, 8'h25, 8'h9F, 0, 16'h0);
        run_frame("blink4", 8'h99, 8'h0D, 8'h25, 8'h9F, 0, 16'h0);
        run_frame("blink5", 8'h99, 8'h0D, 8'h25, 8'h9F, 0, 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
